// File: rtl/dma_timing_fsm_pkg.sv
// ---------------------------------------------------------------------------
// dma_timing_fsm_pkg
// Shared types and constants for the 8237A-style active-cycle timing engine.
//   dma_state_e  : SI/S0/S1/S2/S3/SW/S4 timing states
//   xfer_type_e  : verify / write (IO->mem) / read (mem->IO) / illegal
//   svc_mode_e   : demand / single / block / cascade
//   strobe_t     : the four active-low command strobes as one bundle
//   decode_xfer(): folds the illegal transfer type onto verify
// ---------------------------------------------------------------------------
package dma_timing_fsm_pkg;

    typedef enum logic [2:0] {
        SI = 3'd0,
        S0 = 3'd1,
        S1 = 3'd2,
        S2 = 3'd3,
        S3 = 3'd4,
        SW = 3'd5,
        S4 = 3'd6
    } dma_state_e;

    typedef enum logic [1:0] {
        XFER_VERIFY  = 2'b00,
        XFER_WRITE   = 2'b01,
        XFER_READ    = 2'b10,
        XFER_ILLEGAL = 2'b11
    } xfer_type_e;

    typedef enum logic [1:0] {
        SVC_DEMAND  = 2'b00,
        SVC_SINGLE  = 2'b01,
        SVC_BLOCK   = 2'b10,
        SVC_CASCADE = 2'b11
    } svc_mode_e;

    typedef struct packed {
        logic ior_n;
        logic iow_n;
        logic memr_n;
        logic memw_n;
    } strobe_t;

    // All command strobes released (active low).
    localparam strobe_t STROBES_IDLE = 4'b1111;
    // Internal EOP drive released.
    localparam logic    EOP_IDLE_N   = 1'b1;

    // The illegal code behaves exactly like verify: full timing, no strobes.
    function automatic xfer_type_e decode_xfer(input logic [1:0] raw);
        if (raw == 2'b11) begin
            decode_xfer = XFER_VERIFY;
        end else begin
            decode_xfer = xfer_type_e'(raw);
        end
    endfunction

endpackage

// File: rtl/dma_timing_fsm_if.sv
// ---------------------------------------------------------------------------
// dma_timing_fsm_if
// System-bus handshake and command-strobe bundle of the DMA timing engine.
//   master : the DMA engine (drives HRQ, dack, aen, adstb, strobes, eop_n)
//   slave  : the system side (drives dreq, HLDA, READY, EOP_IN_N)
// Handshake: HRQ/HLDA is a level request/acknowledge pair; the engine holds
// HRQ until it has finished, and only advances out of S0 while HLDA=1.
// READY is a level sampled on each rising edge in S3/SW; a low sample adds
// one wait state.
// ---------------------------------------------------------------------------
interface dma_timing_fsm_if;
    logic dreq;
    logic HLDA;
    logic READY;
    logic EOP_IN_N;
    logic HRQ;
    logic dack;
    logic aen;
    logic adstb;
    logic ior_n;
    logic iow_n;
    logic memr_n;
    logic memw_n;
    logic eop_n;

    modport master (
        input  dreq, HLDA, READY, EOP_IN_N,
        output HRQ, dack, aen, adstb, ior_n, iow_n, memr_n, memw_n, eop_n
    );

    modport slave (
        output dreq, HLDA, READY, EOP_IN_N,
        input  HRQ, dack, aen, adstb, ior_n, iow_n, memr_n, memw_n, eop_n
    );
endinterface

// File: rtl/dma_timing_fsm_addr_count.sv
// ---------------------------------------------------------------------------
// dma_addr_count
// Current address and current word-count registers of the serviced channel.
// Ports:
//   CLK, RESET_N      clock, asynchronous active-low reset (regs clear to 0)
//   i_load            copy base regs into current regs
//   i_step            address +/-1, count -1 (both wrap)
//   i_reload          autoinit reload from base; wins over step and load
//   i_dec             1 = decrement address on step
//   i_base_addr/count base register values
//   o_addr, o_count   current registers
//   o_count_zero      count is zero: the coming step is terminal count
//   o_upper_change    the coming step changes the upper address byte
// ---------------------------------------------------------------------------
module dma_addr_count
    import dma_timing_fsm_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int COUNT_W = 16
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               i_load,
    input  logic               i_step,
    input  logic               i_reload,
    input  logic               i_dec,
    input  logic [ADDR_W-1:0]  i_base_addr,
    input  logic [COUNT_W-1:0] i_base_count,
    output logic [ADDR_W-1:0]  o_addr,
    output logic [COUNT_W-1:0] o_count,
    output logic               o_count_zero,
    output logic               o_upper_change
);

    logic [ADDR_W-1:0]  r_addr;
    logic [COUNT_W-1:0] r_count;
    logic [ADDR_W-1:0]  w_addr_stepped;

    assign w_addr_stepped = i_dec ? (r_addr - ADDR_W'(1)) : (r_addr + ADDR_W'(1));

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_addr  <= '0;
            r_count <= '0;
        end else if (i_reload) begin
            r_addr  <= i_base_addr;
            r_count <= i_base_count;
        end else if (i_step) begin
            r_addr  <= w_addr_stepped;
            r_count <= r_count - COUNT_W'(1);
        end else if (i_load) begin
            r_addr  <= i_base_addr;
            r_count <= i_base_count;
        end
    end

    assign o_addr         = r_addr;
    assign o_count        = r_count;
    assign o_count_zero   = (r_count == '0);
    // A change in A15..A8 forces a fresh S1 so the upper byte is re-strobed.
    assign o_upper_change = (w_addr_stepped[ADDR_W-1:8] != r_addr[ADDR_W-1:8]);

endmodule

// File: rtl/dma_timing_fsm.sv
// ---------------------------------------------------------------------------
// dma_timing_fsm
// Active-cycle timing and control engine of an 8237A-style DMA controller.
// Sequences SI/S0/S1/S2/S3/SW/S4 for demand, single, block and cascade
// service and drives the command strobes seen by the datapath.
// Ports:
//   CLK, RESET_N   clock, asynchronous active-low reset
//   bus            handshake/strobe bundle (master side)
//   xfer_type      00 verify, 01 write, 10 read, 11 treated as verify
//   svc_mode       00 demand, 01 single, 10 block, 11 cascade
//   autoinit       reload current regs from base on termination
//   addr_dec       1 = decrement address
//   load           copy base regs into current regs (honoured only in SI)
//   base_addr/base_count  base register values
//   addr_out, cur_count   current registers
//   tc             terminal-count pulse (one S4 cycle)
//   busy           high in every state except SI
//   dbg_state      current timing state
// Every bus output is a flop loaded from the decode of the next state, so
// each output equals the decode of the present state with no input-to-output
// combinational path.
// ---------------------------------------------------------------------------
module dma_timing_fsm
    import dma_timing_fsm_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int COUNT_W = 16
) (
    input  logic                CLK,
    input  logic                RESET_N,
    dma_timing_fsm_if.master    bus,
    input  logic [1:0]          xfer_type,
    input  logic [1:0]          svc_mode,
    input  logic                autoinit,
    input  logic                addr_dec,
    input  logic                load,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [COUNT_W-1:0]  base_count,
    output logic [ADDR_W-1:0]   addr_out,
    output logic [COUNT_W-1:0]  cur_count,
    output logic                tc,
    output logic                busy,
    output dma_state_e          dbg_state
);

    dma_state_e r_state;
    dma_state_e w_next_state;
    xfer_type_e w_xfer;
    svc_mode_e  w_svc;

    logic w_count_zero;
    logic w_upper_change;
    logic w_terminate;
    logic w_reload;
    logic w_step;
    logic w_load_en;
    logic r_eop_seen;

    logic    r_hrq, r_dack, r_aen, r_adstb, r_tc, r_eop_n, r_busy;
    strobe_t r_strobes;
    logic    w_hrq, w_dack, w_aen, w_adstb, w_tc, w_eop_n, w_busy;
    logic    w_rd_phase, w_wr_phase;
    strobe_t w_strobes;

    assign w_xfer = decode_xfer(xfer_type);
    assign w_svc  = svc_mode_e'(svc_mode);

    // Termination is decided in S4: TC on this word, or EOP seen earlier.
    assign w_terminate = (r_state == S4) && (w_count_zero || r_eop_seen);
    assign w_reload    = w_terminate && autoinit;
    assign w_step      = (r_state == S4) && !w_reload;
    assign w_load_en   = (r_state == SI) && load;

    dma_addr_count #(
        .ADDR_W  (ADDR_W),
        .COUNT_W (COUNT_W)
    ) u_addr_count (
        .CLK            (CLK),
        .RESET_N        (RESET_N),
        .i_load         (w_load_en),
        .i_step         (w_step),
        .i_reload       (w_reload),
        .i_dec          (addr_dec),
        .i_base_addr    (base_addr),
        .i_base_count   (base_count),
        .o_addr         (addr_out),
        .o_count        (cur_count),
        .o_count_zero   (w_count_zero),
        .o_upper_change (w_upper_change)
    );

    // External EOP is latched in S2/S3/SW and consumed by the following S4.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_eop_seen <= 1'b0;
        end else if ((r_state == S4) || (r_state == SI)) begin
            r_eop_seen <= 1'b0;
        end else if (((r_state == S2) || (r_state == S3) || (r_state == SW))
                     && !bus.EOP_IN_N) begin
            r_eop_seen <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= SI;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            SI: begin
                if (bus.dreq) begin
                    w_next_state = S0;
                end
            end
            S0: begin
                if (!bus.dreq) begin
                    w_next_state = SI;
                end else if (bus.HLDA && (w_svc != SVC_CASCADE)) begin
                    w_next_state = S1;
                end
            end
            S1: w_next_state = S2;
            S2: w_next_state = S3;
            S3: w_next_state = bus.READY ? S4 : SW;
            SW: w_next_state = bus.READY ? S4 : SW;
            S4: begin
                if (w_terminate) begin
                    w_next_state = SI;
                end else begin
                    case (w_svc)
                        SVC_BLOCK:  w_next_state = w_upper_change ? S1 : S2;
                        SVC_DEMAND: begin
                            if (bus.dreq) begin
                                w_next_state = w_upper_change ? S1 : S2;
                            end else begin
                                w_next_state = SI;
                            end
                        end
                        default:    w_next_state = SI;
                    endcase
                end
            end
            default: w_next_state = SI;
        endcase
    end

    // Output decode of the state being entered; registered below.
    always_comb begin
        w_rd_phase = (w_next_state == S2) || (w_next_state == S3) || (w_next_state == SW);
        w_wr_phase = (w_next_state == S3) || (w_next_state == SW);
        w_hrq      = (w_next_state != SI);
        w_busy     = (w_next_state != SI);
        w_aen      = (w_next_state == S1) || w_rd_phase || (w_next_state == S4);
        w_adstb    = (w_next_state == S1);
        w_dack     = w_aen;
        // Cascade: the acknowledge is passed straight through to the slave.
        if ((w_next_state == S0) && (w_svc == SVC_CASCADE)) begin
            w_dack = bus.HLDA && bus.dreq;
        end
        // Count is stable from S3/SW into S4, so zero here means TC in S4.
        w_tc       = (w_next_state == S4) && w_count_zero;
        w_eop_n    = w_tc ? 1'b0 : EOP_IDLE_N;
        w_strobes  = STROBES_IDLE;
        case (w_xfer)
            XFER_WRITE: begin
                w_strobes.ior_n  = !w_rd_phase;
                w_strobes.memw_n = !w_wr_phase;
            end
            XFER_READ: begin
                w_strobes.memr_n = !w_rd_phase;
                w_strobes.iow_n  = !w_wr_phase;
            end
            default: w_strobes = STROBES_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_hrq     <= 1'b0;
            r_dack    <= 1'b0;
            r_aen     <= 1'b0;
            r_adstb   <= 1'b0;
            r_tc      <= 1'b0;
            r_eop_n   <= EOP_IDLE_N;
            r_busy    <= 1'b0;
            r_strobes <= STROBES_IDLE;
        end else begin
            r_hrq     <= w_hrq;
            r_dack    <= w_dack;
            r_aen     <= w_aen;
            r_adstb   <= w_adstb;
            r_tc      <= w_tc;
            r_eop_n   <= w_eop_n;
            r_busy    <= w_busy;
            r_strobes <= w_strobes;
        end
    end

    assign bus.HRQ    = r_hrq;
    assign bus.dack   = r_dack;
    assign bus.aen    = r_aen;
    assign bus.adstb  = r_adstb;
    assign bus.ior_n  = r_strobes.ior_n;
    assign bus.iow_n  = r_strobes.iow_n;
    assign bus.memr_n = r_strobes.memr_n;
    assign bus.memw_n = r_strobes.memw_n;
    assign bus.eop_n  = r_eop_n;
    assign tc         = r_tc;
    assign busy       = r_busy;
    assign dbg_state  = r_state;

endmodule

// File: doc/dma_timing_fsm.md
# dma_timing_fsm

Active-cycle timing and control engine of the 8237A DMA controller. It sits directly upstream of the datapath and drives the internal command strobes the datapath gates onto the system bus: `ior`, `iow`, `memr`, `memw`, `eop`, `aen` and `adstb`. It also owns the current address and current word-count registers of the serviced channel, and sequences the SI/S0/S1/S2/S3/SW/S4 states for single, block and demand service.

## Interface
Parameters:
- ADDR_W, 16, address/current-address width
- COUNT_W, 16, word-count width

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
- CLK  in  1  system clock, all state on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- dreq  in  1  arbitrated, unmasked request of the selected channel
- HLDA  in  1  CPU hold acknowledge
- READY  in  1  memory/IO ready, sampled in S3/SW
- EOP_IN_N  in  1  external end-of-process sense, active low
- xfer_type  in  2  00 verify, 01 write (IO→mem), 10 read (mem→IO), 11 illegal (treated as verify)
- svc_mode  in  2  00 demand, 01 single, 10 block, 11 cascade
- autoinit  in  1  reload current regs from base on termination
- addr_dec  in  1  1 = decrement address, 0 = increment
- load  in  1  CPU programming pulse; copies base regs into current regs
- base_addr  in  ADDR_W  base address register value
- base_count  in  COUNT_W  base word-count register value
- HRQ  out  1  hold request to CPU
- dack  out  1  DMA acknowledge to peripheral
- aen, adstb  out  1  address enable / upper-address strobe
- ior_n, iow_n, memr_n, memw_n  out  1  command strobes, active low
- eop_n  out  1  internal EOP drive, active low
- addr_out  out  ADDR_W  current address presented to the datapath
- cur_count  out  COUNT_W  current word count
- tc  out  1  terminal-count pulse
- busy  out  1  high in every state except SI

## Operation
- Reset values: state SI; HRQ, dack, aen, adstb and tc are 0; all `_n` strobes and eop_n are 1; addr_out and cur_count are 0; busy is 0.
- `load` while busy=1 is ignored. In SI, `load` sets addr_out←base_addr and cur_count←base_count.
- **SI:** when dreq=1, assert HRQ and go to S0.
- **S0:** hold HRQ until HLDA=1, then go to S1. If dreq drops before HLDA, return to SI and clear HRQ.
- **S1:** aen=1, adstb=1, dack=1. The upper address byte is valid this cycle.
- **S2:** adstb=0. Read command goes active: write type asserts ior_n=0; read type asserts memr_n=0.
- **S3:** write command goes active: write type asserts memw_n=0; read type asserts iow_n=0. If READY=0, go to SW; otherwise go to S4.
- **SW:** hold all strobes. Leave for S4 on the first cycle with READY=1.
- **S4:** deassert all strobes. Update address by ±1 (mod 2^ADDR_W) and decrement count (mod 2^COUNT_W).
  - tc=1 and eop_n=0 for this one cycle when cur_count was 0 on entry (count wraps to all-ones).
- **Verify:** runs the full state sequence but asserts no command strobes.
- **Termination** (TC, or EOP_IN_N=0 sampled in S2/S3/SW): finish S4, then go to SI and drop HRQ, aen and dack. If autoinit=1, current regs ← base regs in the same S4 edge. Autoinit reload has priority over the S4 update.
- **Continuation after S4 when not terminated:**
  - single: go to SI.
  - block: continue.
  - demand: continue while dreq=1, else go to SI.
  - Continue target: S2 if the upper address byte is unchanged, else S1.
- **Cascade:** HRQ follows dreq; dack = HLDA & dreq. No strobes, aen stays 0, and the FSM stays in S0 until dreq=0.

## Timing
- dreq sampled high in SI → HRQ=1 on the next edge.
- HLDA sampled high in S0 → S1 on the next edge.
- Single transfer with READY=1: S1, S2, S3, S4 take 4 clocks after S0 exits. dack is high for exactly these 4 cycles.
- Each READY=0 sample adds exactly one SW cycle.
- Block transfer with no upper-byte change: 3 clocks per word (S2, S3, S4).
- All outputs are registered from the state, with no combinational path from inputs to outputs.
- RESET_N low mid-transfer: return immediately to reset values; the transfer is abandoned and current regs clear to 0.

## Structure
- Add to DmaPackage:
  - `dma_state_e` {SI, S0, S1, S2, S3, SW, S4}
  - `xfer_type_e`
  - `svc_mode_e`
  - strobe-idle constants
- One sub-module, `dma_addr_count`: the current address/count registers with load, step, autoinit reload and TC detect.
- The FSM stays in `dma_timing_fsm`.

## Test plan
- **Single write:** load base_addr=0x1234, base_count=0x0001; dreq then HLDA. Expect S1–S4, ior_n=0 in S2–S3, memw_n=0 in S3, addr_out=0x1235, cur_count=0x0000, tc=0, then return to SI.
- **Block read with wrap:** base_addr=0x12FF, count=0x0002. Expect S1 revisited at address 0x1300, three words transferred, tc and eop_n pulse on the third S4, HRQ=0 afterwards.
- **READY stretch:** READY=0 for 3 cycles in S3. Expect exactly 3 SW cycles with strobes held and S4 on the first READY=1.
- **External EOP plus autoinit:** demand mode, EOP_IN_N=0 in S3 of word 2. Expect termination after that S4 and current regs reloaded to base values.
- **Verify plus decrement:** verify type, addr_dec=1, addr=0x0000. Expect no strobe ever low and addr_out=0xFFFF after S4.
- **Reset mid-SW:** RESET_N low during SW. Expect all strobes high, HRQ=0 and state SI asynchronously.
